// File: rtl/imem_load_arbiter_pkg.sv
// Shared types and constants for the instruction-memory load arbiter.
// The optional checksum feature is enabled with the IMEM_CKSUM_EN macro.
package imem_pkg;

    localparam int          IMEM_ADDR_W      = 9;
    localparam logic [31:0] IMEM_NOP         = 32'h0000_0000;
    localparam int          IMEM_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        LOAD   = 2'd1,
        RESUME = 2'd2,
        RUN    = 2'd3
    } imem_state_e;

    // Running image checksum: XOR of every accepted data word.
    function automatic logic [31:0] cksum_fold(input logic [31:0] acc, input logic [31:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_load_arbiter_if.sv
// CPU fetch, loader handshake and memory port bundle of the load arbiter.
// slave = arbiter side, master = surrounding CPU / loader / memory.
interface imem_load_arbiter_if #(
    parameter int ADDR_W = imem_pkg::IMEM_ADDR_W
);
    logic [31:0]     cpu_pc;
    logic [31:0]     cpu_instr;
    logic            cpu_stall;
    logic            ld_valid;
    logic            ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]     ld_data;
    logic            ld_last;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]     mem_wdata;
    logic            mem_we;
    logic [31:0]     mem_rdata;
    logic            load_busy;
    logic [ADDR_W:0] load_count;
    logic            load_err;

    modport slave (
        input  cpu_pc, ld_valid, ld_addr, ld_data, ld_last, mem_rdata,
        output cpu_instr, cpu_stall, ld_ready, mem_addr, mem_wdata, mem_we,
               load_busy, load_count, load_err
    );

    modport master (
        output cpu_pc, ld_valid, ld_addr, ld_data, ld_last, mem_rdata,
        input  cpu_instr, cpu_stall, ld_ready, mem_addr, mem_wdata, mem_we,
               load_busy, load_count, load_err
    );
endinterface

// File: rtl/imem_idle_timer.sv
// Idle-cycle counter between loader beats; terminal flags TIMEOUT-1 idle cycles.
module imem_idle_timer #(
    parameter int TIMEOUT = imem_pkg::IMEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic terminal
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // Idle counter: clear wins, then saturating increment at the terminal value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign terminal = (cnt_r == LAST);
endmodule

// File: rtl/imem_load_arbiter.sv
// Shares the single instruction-memory port between CPU fetch and a program loader.
// Define IMEM_CKSUM_EN to add the load_cksum output (XOR of the current image's words).
module imem_load_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W  = IMEM_ADDR_W,
    parameter int TIMEOUT = IMEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    imem_load_arbiter_if.slave bus
`ifdef IMEM_CKSUM_EN
    ,
    output logic [31:0] load_cksum
`endif
);
    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    imem_state_e       state_r, next_state_s;
    logic              ld_ready_s;
    logic              accept_s;
    logic              load_entry_s;
    logic              timer_clr_s;
    logic              timer_inc_s;
    logic              timer_term_s;
    logic              timeout_s;
    logic [ADDR_W:0]   load_count_r;
    logic              load_err_r;
    logic [ADDR_W-1:0] pc_index_s;
    logic              unused_pc_bits_s;

    assign pc_index_s       = bus.cpu_pc[ADDR_W+1:2];
    assign unused_pc_bits_s = ^{bus.cpu_pc[31:ADDR_W+2], bus.cpu_pc[1:0]};
    assign accept_s         = bus.ld_valid & ld_ready_s;
    assign load_entry_s     = (state_r == RUN) & bus.ld_valid;
    assign timer_clr_s      = accept_s | (state_r != LOAD);
    assign timer_inc_s      = (state_r == LOAD) & ~accept_s;
    assign timeout_s        = (state_r == LOAD) & ~accept_s & timer_term_s;

    imem_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr_s),
        .inc      (timer_inc_s),
        .terminal (timer_term_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= BOOT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            BOOT: begin
                if (accept_s && bus.ld_last) next_state_s = RESUME;
                else                         next_state_s = BOOT;
            end
            LOAD: begin
                if (accept_s && bus.ld_last) next_state_s = RESUME;
                else if (timeout_s)          next_state_s = RESUME;
                else                         next_state_s = LOAD;
            end
            RESUME: next_state_s = RUN;
            RUN: begin
                if (bus.ld_valid) next_state_s = LOAD;
                else              next_state_s = RUN;
            end
            default: next_state_s = BOOT;
        endcase
    end

    // Output decode: the loader owns the port in BOOT/LOAD, fetch otherwise.
    always_comb begin
        ld_ready_s    = 1'b0;
        bus.cpu_stall = 1'b1;
        bus.load_busy = 1'b1;
        bus.mem_addr  = pc_index_s;
        bus.cpu_instr = IMEM_NOP;
        case (state_r)
            BOOT, LOAD: begin
                ld_ready_s   = 1'b1;
                bus.mem_addr = bus.ld_addr;
            end
            RESUME: begin
                ld_ready_s   = 1'b0;
                bus.mem_addr = pc_index_s;
            end
            RUN: begin
                bus.cpu_stall = 1'b0;
                bus.load_busy = 1'b0;
                bus.cpu_instr = bus.mem_rdata;
            end
            default: begin
                ld_ready_s = 1'b0;
            end
        endcase
    end

    assign bus.ld_ready   = ld_ready_s;
    assign bus.mem_we     = accept_s;
    assign bus.mem_wdata  = bus.ld_data;
    assign bus.load_count = load_count_r;
    assign bus.load_err   = load_err_r;

    // Beat counter: restarts when a reload begins, saturates at the memory depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_count_r <= {(ADDR_W+1){1'b0}};
        end else if (load_entry_s) begin
            load_count_r <= {(ADDR_W+1){1'b0}};
        end else if (accept_s && (load_count_r != COUNT_MAX)) begin
            load_count_r <= load_count_r + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
            load_count_r <= load_count_r;
        end
    end

    // Sticky timeout flag, cleared by the next accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_err_r <= 1'b0;
        end else if (timeout_s) begin
            load_err_r <= 1'b1;
        end else if (accept_s) begin
            load_err_r <= 1'b0;
        end else begin
            load_err_r <= load_err_r;
        end
    end

`ifdef IMEM_CKSUM_EN
    logic [31:0] cksum_r;

    // Image checksum, restarted on reset and at the start of every reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cksum_r <= 32'h0000_0000;
        end else if (load_entry_s) begin
            cksum_r <= 32'h0000_0000;
        end else if (accept_s) begin
            cksum_r <= cksum_fold(cksum_r, bus.ld_data);
        end else begin
            cksum_r <= cksum_r;
        end
    end

    assign load_cksum = cksum_r;
`endif
endmodule
